// File: rtl/cbb_rs_pkg.sv
// Shared constants and helpers for the cbb_rs register-slice family.
// Holds the stage-count limit, the statistics counter width and a popcount helper.
package cbb_rs_pkg;

    localparam int unsigned CBB_RS_MAX_STAGES = 8;
    localparam int unsigned CBB_RS_STAT_W     = 32;

    // Counts set bits of a stage-valid vector padded out to the stage limit.
    function automatic int unsigned cbb_rs_popcount(
        input logic [CBB_RS_MAX_STAGES-1:0] vec
    );
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < CBB_RS_MAX_STAGES; i++) begin
            cnt = cnt + int'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cbb_rs_fwd_stage.sv
// One forward register stage: a single valid/data flop pair with a
// bubble-collapsing ready (ready whenever empty or downstream is ready).
module cbb_rs_fwd_stage
    import cbb_rs_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    up_valid_i,
    input  logic [P_DATA_WIDTH-1:0] up_data_i,
    output logic                    up_ready_o,
    output logic                    dn_valid_o,
    output logic [P_DATA_WIDTH-1:0] dn_data_o,
    input  logic                    dn_ready_i
);

    // Handshake: a beat moves across a port on a rising edge where valid and
    // ready are both high; a producer holds valid/data until that happens.
    logic                    vld_q;
    logic                    vld_d;
    logic [P_DATA_WIDTH-1:0] dat_q;
    logic [P_DATA_WIDTH-1:0] dat_d;

    assign up_ready_o = dn_ready_i | ~vld_q;

    // Data only loads on a real upstream beat so an emptied stage keeps its last payload.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (up_ready_o) begin
            vld_d = up_valid_i;
            if (up_valid_i) begin
                dat_d = up_data_i;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign dn_valid_o = vld_q;
    assign dn_data_o  = dat_q;

endmodule

// File: rtl/cbb_rs_forward.sv
// Cascaded forward register slice: P_STAGES registered valid/data stages with a
// combinational bubble-collapsing ready chain. Optional macro CBB_RS_FWD_STAT_EN adds o_xfer_cnt.
module cbb_rs_forward
    import cbb_rs_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 64,
    parameter int unsigned P_STAGES     = 2
) (
    input  logic                             i_clk,
    input  logic                             i_rstn,
    input  logic                             slv_i_valid,
    input  logic [P_DATA_WIDTH-1:0]          slv_i_data,
    output logic                             slv_o_ready,
    output logic                             mst_o_valid,
    output logic [P_DATA_WIDTH-1:0]          mst_o_data,
    input  logic                             mst_i_ready,
    output logic [$clog2(P_STAGES+1)-1:0]    o_occupancy
`ifdef CBB_RS_FWD_STAT_EN
    ,
    output logic [CBB_RS_STAT_W-1:0]         o_xfer_cnt
`endif
);

    localparam int unsigned OCC_W = $clog2(P_STAGES + 1);

    logic [P_STAGES-1:0]          vld_vec;
    logic [CBB_RS_MAX_STAGES-1:0] vld_ext;

    // Each stage keeps its own link signals; neighbours are reached by index so
    // the ready chain never folds back onto a single shared vector.
    for (genvar k = 0; k < P_STAGES; k++) begin : g_stage
        logic                    up_vld;
        logic [P_DATA_WIDTH-1:0] up_dat;
        logic                    up_rdy;
        logic                    dn_rdy;
        logic                    vld;
        logic [P_DATA_WIDTH-1:0] dat;

        if (k == 0) begin : g_head
            assign up_vld = slv_i_valid;
            assign up_dat = slv_i_data;
        end else begin : g_link
            assign up_vld = g_stage[k-1].vld;
            assign up_dat = g_stage[k-1].dat;
        end

        if (k == P_STAGES - 1) begin : g_tail
            assign dn_rdy = mst_i_ready;
        end else begin : g_chain
            assign dn_rdy = g_stage[k+1].up_rdy;
        end

        cbb_rs_fwd_stage #(
            .P_DATA_WIDTH (P_DATA_WIDTH)
        ) u_stage (
            .i_clk      (i_clk),
            .i_rstn     (i_rstn),
            .up_valid_i (up_vld),
            .up_data_i  (up_dat),
            .up_ready_o (up_rdy),
            .dn_valid_o (vld),
            .dn_data_o  (dat),
            .dn_ready_i (dn_rdy)
        );

        assign vld_vec[k] = vld;
    end

    assign slv_o_ready = g_stage[0].up_rdy;
    assign mst_o_valid = g_stage[P_STAGES-1].vld;
    assign mst_o_data  = g_stage[P_STAGES-1].dat;

    // Occupancy is a pure function of the stage valid flops.
    always_comb begin
        vld_ext                = '0;
        vld_ext[P_STAGES-1:0]  = vld_vec;
    end

    assign o_occupancy = OCC_W'(cbb_rs_popcount(vld_ext));

`ifdef CBB_RS_FWD_STAT_EN
    logic [CBB_RS_STAT_W-1:0] xfer_cnt_q;
    logic [CBB_RS_STAT_W-1:0] xfer_cnt_d;

    // Counts downstream beats; wraps naturally at the counter width.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (mst_o_valid && mst_i_ready) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign o_xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_cbb_rs_forward.sv
// Directed bench for cbb_rs_forward (P_STAGES=2, P_DATA_WIDTH=64): vector table,
// streaming, async reset, and a random valid/ready run with an expected queue.
module tb_cbb_rs_forward;

    localparam int W = 64;

    logic          i_clk;
    logic          i_rstn;
    logic          slv_i_valid;
    logic [W-1:0]  slv_i_data;
    logic          slv_o_ready;
    logic          mst_o_valid;
    logic [W-1:0]  mst_o_data;
    logic          mst_i_ready;
    logic [1:0]    o_occupancy;
`ifdef CBB_RS_FWD_STAT_EN
    logic [31:0]   o_xfer_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    logic [W-1:0] exp_q[$];

    cbb_rs_forward #(
        .P_DATA_WIDTH (W),
        .P_STAGES     (2)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .slv_i_valid (slv_i_valid),
        .slv_i_data  (slv_i_data),
        .slv_o_ready (slv_o_ready),
        .mst_o_valid (mst_o_valid),
        .mst_o_data  (mst_o_data),
        .mst_i_ready (mst_i_ready),
        .o_occupancy (o_occupancy)
`ifdef CBB_RS_FWD_STAT_EN
        ,
        .o_xfer_cnt  (o_xfer_cnt)
`endif
    );

    // Clock and watchdog
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then settle at the falling edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        @(posedge i_clk);
        #1;
        slv_i_valid = v;
        slv_i_data  = d;
        mst_i_ready = r;
        @(negedge i_clk);
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         e_srdy;
        logic         e_mv;
        logic [W-1:0] e_md;
        logic [1:0]   e_occ;
    } vec_t;

    vec_t vecs[12];

    int          exp_xfer;
    int          tx;
    int          rx;
    int          cyc;
    bit          offering;
    bit          prev_stall;
    logic [W-1:0] cur;
    logic [W-1:0] prev_data;

    initial begin
        // Single push then fill/stall/drain; expected outputs are those seen before each edge.
        vecs[0]  = '{1'b1, 64'hA5A5, 1'b1, 1'b1, 1'b0, 64'h0,    2'd0};
        vecs[1]  = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b0, 64'h0,    2'd1};
        vecs[2]  = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 64'hA5A5, 2'd1};
        vecs[3]  = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b0, 64'hA5A5, 2'd0};
        vecs[4]  = '{1'b1, 64'h11,   1'b0, 1'b1, 1'b0, 64'hA5A5, 2'd0};
        vecs[5]  = '{1'b1, 64'h22,   1'b0, 1'b1, 1'b0, 64'hA5A5, 2'd1};
        vecs[6]  = '{1'b1, 64'h33,   1'b0, 1'b0, 1'b1, 64'h11,   2'd2};
        vecs[7]  = '{1'b1, 64'h33,   1'b0, 1'b0, 1'b1, 64'h11,   2'd2};
        vecs[8]  = '{1'b1, 64'h33,   1'b1, 1'b1, 1'b1, 64'h11,   2'd2};
        vecs[9]  = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 64'h22,   2'd2};
        vecs[10] = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 64'h33,   2'd1};
        vecs[11] = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b0, 64'h33,   2'd0};

        // Reset and idle
        i_rstn      = 1'b0;
        slv_i_valid = 1'b0;
        slv_i_data  = '0;
        mst_i_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge i_clk);
        check("idle_mst_valid", mst_o_valid, 0);
        check("idle_occupancy", o_occupancy, 0);
        check("idle_slv_ready", slv_o_ready, 1);
        check("idle_mst_data",  mst_o_data,  0);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].r);
            check($sformatf("vec%0d_slv_ready", i), slv_o_ready, vecs[i].e_srdy);
            check($sformatf("vec%0d_mst_valid", i), mst_o_valid, vecs[i].e_mv);
            check($sformatf("vec%0d_mst_data", i),  mst_o_data,  vecs[i].e_md);
            check($sformatf("vec%0d_occupancy", i), o_occupancy, vecs[i].e_occ);
        end

        // Back-to-back stream 0x1..0x10 with the sink always ready
        for (int c = 0; c < 20; c++) begin
            step(c < 16, (c < 16) ? W'(c + 1) : '0, 1'b1);
            if (c < 16) check($sformatf("stream%0d_slv_ready", c), slv_o_ready, 1);
            check($sformatf("stream%0d_mst_valid", c), mst_o_valid, (c >= 2 && c < 18));
            if (c >= 2 && c < 18) check($sformatf("stream%0d_mst_data", c), mst_o_data, W'(c - 1));
        end

        // Asynchronous reset with two payloads in flight
        step(1'b1, 64'h44, 1'b0);
        step(1'b1, 64'h55, 1'b0);
        step(1'b0, 64'h0,  1'b0);
        check("prereset_occupancy", o_occupancy, 2);
        check("prereset_mst_data",  mst_o_data,  64'h44);
        #2;
        i_rstn = 1'b0;
        #1;
        check("rst_mst_valid", mst_o_valid, 0);
        check("rst_mst_data",  mst_o_data,  0);
        check("rst_occupancy", o_occupancy, 0);
        check("rst_slv_ready", slv_o_ready, 1);
`ifdef CBB_RS_FWD_STAT_EN
        check("rst_xfer_cnt", o_xfer_cnt, 0);
`endif
        @(negedge i_clk);
        i_rstn = 1'b1;
        step(1'b1, 64'h77, 1'b1);
        check("postrst_c0_valid", mst_o_valid, 0);
        step(1'b0, 64'h0, 1'b1);
        check("postrst_c1_valid", mst_o_valid, 0);
        step(1'b0, 64'h0, 1'b1);
        check("postrst_c2_valid", mst_o_valid, 1);
        check("postrst_c2_data",  mst_o_data,  64'h77);
        step(1'b0, 64'h0, 1'b1);
        check("postrst_c3_valid", mst_o_valid, 0);
        check("postrst_c3_occ",   o_occupancy, 0);
        exp_xfer = 1;

        // Random valid/ready, 1000 payloads through the expected queue
        tx = 0;
        rx = 0;
        cyc = 0;
        offering = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        cur = '0;
        while (rx < 1000 && cyc < 20000) begin
            @(posedge i_clk);
            #1;
            if (!offering && tx < 1000 && $urandom_range(0, 1) == 1) begin
                offering = 1'b1;
                cur = {$urandom, $urandom};
            end
            slv_i_valid = offering;
            slv_i_data  = offering ? cur : '0;
            mst_i_ready = ($urandom_range(0, 1) == 1);
            @(negedge i_clk);
            if (prev_stall) begin
                check("stall_valid", mst_o_valid, 1);
                check("stall_data",  mst_o_data,  prev_data);
            end
            prev_stall = mst_o_valid && !mst_i_ready;
            prev_data  = mst_o_data;
            if (offering && slv_o_ready) begin
                exp_q.push_back(cur);
                tx++;
                offering = 1'b0;
            end
            if (mst_o_valid && mst_i_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL rand_extra: got %h expected no beat", mst_o_data);
                end else begin
                    check("rand_data", mst_o_data, exp_q.pop_front());
                end
                rx++;
            end
            cyc++;
        end
        check("rand_count", W'(rx), W'(1000));
        check("rand_queue_empty", W'(exp_q.size()), W'(0));
        exp_xfer = exp_xfer + rx;
        step(1'b0, 64'h0, 1'b0);
        check("final_occupancy", o_occupancy, 0);
`ifdef CBB_RS_FWD_STAT_EN
        check("final_xfer_cnt", o_xfer_cnt, W'(exp_xfer));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
